// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - shared types and defaults for the AES encrypt sequencer
package aes_seq_pkg;

    typedef logic [127:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BUSY
    } seq_state_e;

    localparam int SEQ_DEPTH   = 2;
    localparam int SEQ_TIMEOUT = 31;

endpackage

// File: rtl/aes_seq_fifo.sv
// rtl/aes_seq_fifo.sv - synchronous ciphertext FIFO with occupancy count
module aes_seq_fifo
    import aes_seq_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  aes_blk_t                     push_data,
    input  logic                         pop,
    output aes_blk_t                     head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    aes_blk_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_enc_sequencer.sv
// rtl/aes_enc_sequencer.sv - feeds aes_cipher_top one block at a time and buffers ciphertext
module aes_enc_sequencer
    import aes_seq_pkg::*;
#(
    parameter int DEPTH   = SEQ_DEPTH,
    parameter int TIMEOUT = SEQ_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  aes_blk_t      in_key,
    input  aes_blk_t      in_text,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          core_ld,
    output aes_blk_t      core_key,
    output aes_blk_t      core_text_in,
    input  logic          core_done,
    input  aes_blk_t      core_text_out,
    output aes_blk_t      out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          err,
    output logic [15:0]   blk_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    seq_state_e      state;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;

    // Acceptance reserves a buffer slot, so a completion never finds the FIFO full.
    assign in_ready  = (state == IDLE) && (count < CW'(DEPTH));
    assign busy      = (state != IDLE);
    assign out_valid = !empty;
    assign push      = (state == BUSY) && core_done && !full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            core_ld      <= 1'b0;
            core_key     <= '0;
            core_text_in <= '0;
            timer        <= '0;
            err          <= 1'b0;
            blk_cnt      <= '0;
        end else begin
            core_ld <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        core_key     <= in_key;
                        core_text_in <= in_text;
                        core_ld      <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    timer <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    // A completion on the last allowed cycle still counts as success.
                    if (core_done) begin
                        blk_cnt <= blk_cnt + 16'd1;
                        state   <= IDLE;
                    end else if (timer == TMAX) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    aes_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (core_text_out),
        .pop       (out_valid && out_ready),
        .head      (out_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_aes_enc_sequencer.sv
// tb/tb_aes_enc_sequencer.sv - directed bench for aes_enc_sequencer with a latency-programmable core stub
module tb_aes_enc_sequencer;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] key;
        logic [127:0] text;
        int           lat;
        logic [127:0] ct;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [127:0]   in_key;
    logic [127:0]   in_text;
    logic           in_valid;
    logic           in_ready;
    logic           core_ld;
    logic [127:0]   core_key;
    logic [127:0]   core_text_in;
    logic           core_done = 1'b0;
    logic [127:0]   core_text_out = '0;
    logic [127:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           err;
    logic [15:0]    blk_cnt;

    int             checks = 0;
    int             failures = 0;
    int             lat = 1;
    int             cur_lat = 0;
    int             k = 0;
    int             ld_cnt = 0;
    logic           armed = 1'b0;
    logic [127:0]   got [$];
    vec_t           vecs [4];

    always #5 clk = ~clk;

    aes_enc_sequencer #(
        .DEPTH   (2),
        .TIMEOUT (31)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_key        (in_key),
        .in_text       (in_text),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .core_ld       (core_ld),
        .core_key      (core_key),
        .core_text_in  (core_text_in),
        .core_done     (core_done),
        .core_text_out (core_text_out),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .err           (err),
        .blk_cnt       (blk_cnt)
    );

    function automatic logic [127:0] ct_of(input logic [127:0] kk, input logic [127:0] tt);
        if (kk == FIPS_KEY && tt == FIPS_PT) return FIPS_CT;
        return kk ^ tt;
    endfunction

    // Core stub: done pulses lat cycles after the ld cycle (lat=0 never completes).
    always @(negedge clk) begin
        core_done = 1'b0;
        if (!rst) begin
            armed = 1'b0;
        end else begin
            if (armed) begin
                k = k + 1;
                if (k == cur_lat) begin
                    core_done     = 1'b1;
                    core_text_out = ct_of(core_key, core_text_in);
                    armed         = 1'b0;
                end
            end
            if (core_ld) begin
                ld_cnt  = ld_cnt + 1;
                armed   = (lat > 0);
                cur_lat = lat;
                k       = 0;
            end
            if (out_valid && out_ready) got.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] kk, input logic [127:0] tt, input int l);
        lat      = l;
        in_key   = kk;
        in_text  = tt;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !in_ready; n++) tick();
        chk("send_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && busy; n++) tick();
        chk("wait_idle", 128'(busy), 128'(1'b0));
    endtask

    task automatic wait_out();
        for (int n = 0; n < 200 && !out_valid; n++) tick();
        chk("wait_out_valid", 128'(out_valid), 128'(1'b1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready),  128'(1'b1));
        chk({tag, "_core_ld"},   128'(core_ld),   128'(1'b0));
        chk({tag, "_core_key"},  core_key,        128'h0);
        chk({tag, "_core_text"}, core_text_in,    128'h0);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
        chk({tag, "_busy"},      128'(busy),      128'(1'b0));
        chk({tag, "_err"},       128'(err),       128'(1'b0));
        chk({tag, "_blk_cnt"},   128'(blk_cnt),   128'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [15:0] cnt0;
        int          ld0;

        vecs[0] = '{FIPS_KEY, FIPS_PT, 3, FIPS_CT};
        vecs[1] = '{128'h1111_1111_1111_1111_1111_1111_1111_1111,
                    128'h2222_2222_2222_2222_2222_2222_2222_2222, 5,
                    128'h3333_3333_3333_3333_3333_3333_3333_3333};
        vecs[2] = '{128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff,
                    128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef, 1,
                    128'hfedc_ba98_7654_3210_fedc_ba98_7654_3210};
        vecs[3] = '{128'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f,
                    128'hf0f0_f0f0_f0f0_f0f0_f0f0_f0f0_f0f0_f0f0, 32,
                    128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff};

        rst = 1'b0; in_valid = 1'b0; in_key = '0; in_text = '0; out_ready = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        rst = 1'b1;
        out_ready = 1'b1;

        // Table: latency 32 completes exactly on the watchdog cycle and must still be written.
        for (int i = 0; i < 4; i++) begin
            ld0  = ld_cnt;
            cnt0 = blk_cnt;
            send(vecs[i].key, vecs[i].text, vecs[i].lat);
            chk($sformatf("v%0d_ld_pulse", i), 128'(core_ld), 128'(1'b1));
            chk($sformatf("v%0d_busy", i), 128'(busy), 128'(1'b1));
            chk($sformatf("v%0d_in_ready_low", i), 128'(in_ready), 128'(1'b0));
            tick();
            chk($sformatf("v%0d_ld_single", i), 128'(core_ld), 128'(1'b0));
            chk($sformatf("v%0d_hold_key", i), core_key, vecs[i].key);
            wait_out();
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].ct);
            chk($sformatf("v%0d_blk_cnt", i), 128'(blk_cnt), 128'(cnt0 + 16'd1));
            chk($sformatf("v%0d_err", i), 128'(err), 128'(1'b0));
            chk($sformatf("v%0d_in_ready_again", i), 128'(in_ready), 128'(1'b1));
            chk($sformatf("v%0d_ld_count", i), 128'(ld_cnt - ld0), 128'(1));
            tick();
            chk($sformatf("v%0d_drained", i), 128'(out_valid), 128'(1'b0));
        end

        // Back-pressure: two fill the buffer, the third waits upstream.
        out_ready = 1'b0;
        got.delete();
        cnt0 = blk_cnt;
        ld0  = ld_cnt;
        send(128'h1, 128'h2, 3);
        wait_idle();
        send(128'h4, 128'h8, 3);
        wait_idle();
        in_key = 128'h10; in_text = 128'h20; in_valid = 1'b1; lat = 3;
        repeat (10) tick();
        chk("bp_in_ready_full", 128'(in_ready), 128'(1'b0));
        chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
        chk("bp_head", out_data, 128'h3);
        chk("bp_blk_cnt", 128'(blk_cnt), 128'(cnt0 + 16'd2));
        chk("bp_ld_count", 128'(ld_cnt - ld0), 128'(2));
        out_ready = 1'b1;
        send(128'h10, 128'h20, 3);
        wait_idle();
        for (int n = 0; n < 50 && got.size() < 3; n++) tick();
        chk("bp_got_count", 128'(got.size()), 128'(3));
        if (got.size() >= 3) begin
            chk("bp_order0", got[0], 128'h3);
            chk("bp_order1", got[1], 128'hc);
            chk("bp_order2", got[2], 128'h30);
        end

        // Push and pop on the same edge with one entry buffered.
        out_ready = 1'b0;
        got.delete();
        send(128'h100, 128'h200, 1);
        wait_idle();
        send(128'h400, 128'h800, 4);
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        chk("pp_out_valid", 128'(out_valid), 128'(1'b1));
        chk("pp_new_head", out_data, 128'hc00);
        chk("pp_idle", 128'(busy), 128'(1'b0));
        tick();
        chk("pp_empty", 128'(out_valid), 128'(1'b0));
        chk("pp_got_count", 128'(got.size()), 128'(2));
        if (got.size() >= 2) begin
            chk("pp_old_first", got[0], 128'h300);
            chk("pp_new_second", got[1], 128'hc00);
        end

        // Watchdog: core never completes.
        cnt0 = blk_cnt;
        send(128'hdead, 128'hbeef, 0);
        repeat (32) tick();
        chk("wd_err_before", 128'(err), 128'(1'b0));
        chk("wd_busy_before", 128'(busy), 128'(1'b1));
        tick();
        chk("wd_err_set", 128'(err), 128'(1'b1));
        chk("wd_idle", 128'(busy), 128'(1'b0));
        chk("wd_in_ready", 128'(in_ready), 128'(1'b1));
        chk("wd_no_write", 128'(out_valid), 128'(1'b0));
        chk("wd_blk_cnt", 128'(blk_cnt), 128'(cnt0));
        send(128'h5, 128'ha, 2);
        wait_out();
        chk("wd_good_data", out_data, 128'hf);
        chk("wd_err_sticky", 128'(err), 128'(1'b1));
        tick();

        // Reset with one buffered block and one in flight.
        out_ready = 1'b0;
        send(vecs[1].key, vecs[1].text, 1);
        wait_idle();
        send(vecs[2].key, vecs[2].text, 20);
        repeat (5) tick();
        chk("rb_busy", 128'(busy), 128'(1'b1));
        rst = 1'b0;
        tick();
        check_reset_values("rb");
        rst = 1'b1;

        // Reset with the buffer full.
        send(128'h1, 128'h2, 1);
        wait_idle();
        send(128'h4, 128'h8, 1);
        wait_idle();
        chk("rf_full", 128'(in_ready), 128'(1'b0));
        rst = 1'b0;
        tick();
        check_reset_values("rf");
        rst = 1'b1;

        out_ready = 1'b1;
        send(FIPS_KEY, FIPS_PT, 6);
        wait_out();
        chk("post_rst_ct", out_data, FIPS_CT);
        chk("post_rst_blk_cnt", 128'(blk_cnt), 128'(16'd1));
        chk("post_rst_err", 128'(err), 128'(1'b0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_enc_sequencer.md
# aes_enc_sequencer

Block-level sequencer in front of `aes_cipher_top`. It accepts key/plaintext pairs over a valid/ready stream and issues the single-cycle `ld` strobe the core expects. It waits for the core's `done`, captures `text_out` into a 2-entry output buffer, and presents ciphertext on a valid/ready stream with back-pressure. A watchdog flags a core that never completes.

## Interface
Parameters:
- `DEPTH`, 2: output buffer entries; power of two, ≥2.
- `TIMEOUT`, 31: maximum cycles in BUSY waiting for `core_done` before aborting.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_key`  in  128  cipher key for this block.
- `in_text`  in  128  plaintext block.
- `in_valid`  in  1  upstream has a block.
- `in_ready`  out  1  sequencer accepts; transfer when `in_valid && in_ready`.
- `core_ld`  out  1  one-cycle load strobe to `aes_cipher_top.ld`.
- `core_key`  out  128  held key to `aes_cipher_top.key`.
- `core_text_in`  out  128  held plaintext to `aes_cipher_top.text_in`.
- `core_done`  in  1  `aes_cipher_top.done`.
- `core_text_out`  in  128  `aes_cipher_top.text_out`; sampled only when `core_done`=1.
- `out_data`  out  128  ciphertext at buffer head.
- `out_valid`  out  1  buffer non-empty.
- `out_ready`  in  1  downstream accepts; pop when `out_valid && out_ready`.
- `busy`  out  1  state ≠ IDLE.
- `err`  out  1  sticky watchdog flag; cleared only by reset.
- `blk_cnt`  out  16  count of ciphertext blocks written to buffer; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, LOAD, BUSY.
- IDLE:
  - `in_ready` = (buffer count < DEPTH).
  - On transfer: capture `in_key`/`in_text` into holding regs driving `core_key`/`core_text_in`; go to LOAD.
- LOAD:
  - `core_ld`=1 for exactly this cycle; clear timer; go to BUSY.
- BUSY:
  - Timer increments each cycle.
  - If `core_done`: write `core_text_out` to buffer, `blk_cnt`+1, go to IDLE.
  - Else if timer == TIMEOUT: set `err`, discard block (no write, no count), go to IDLE.
  - `core_done` on the timeout cycle wins, and the block is written.
- `core_done` outside BUSY is ignored.
- At most one block in flight. IDLE acceptance requires a free entry, so a completion always has buffer space. No overflow path exists.
- `in_ready`=0 in LOAD and BUSY.
- Holding regs are stable from LOAD until the next accept; the core may sample them any time after `ld`.
- Buffer is a FIFO in acceptance order. Push and pop in the same cycle: count unchanged, data order preserved. Pop when empty is impossible because `out_valid`=0.
- Timer width is $clog2(TIMEOUT+1) and saturates.

## Timing
- Reset values: `in_ready`=1, `core_ld`=0, `core_key`=0, `core_text_in`=0, `out_data`=0 (don't-care), `out_valid`=0, `busy`=0, `err`=0, `blk_cnt`=0; state IDLE; buffer empty; timer 0.
- Reset mid-operation:
  - The in-flight block and all buffered blocks are lost.
  - `core_ld` is never asserted in the reset cycle.
  - The core shares `rst` and is reset alongside.
- Input transfer at cycle N:
  - `core_ld`=1 at N+1.
  - BUSY from N+2.
- `core_done` at cycle D: buffer write at the D edge; `out_valid`=1 at D+1. Earliest next `in_ready`=1 is D+1.
- Throughput: one block per (core latency + 2) cycles.
- `out_data`/`out_valid` are registered; no combinational path from `out_ready` to `in_ready` except via count. `in_ready` may be combinational from state and count.

## Structure
- Package `aes_seq_pkg`:
  - `typedef logic [127:0] aes_blk_t`.
  - State enum `seq_state_e` {IDLE, LOAD, BUSY}.
  - Default constants `SEQ_DEPTH`=2 and `SEQ_TIMEOUT`=31.
- Sub-module `aes_seq_fifo`: parameterised synchronous FIFO (DEPTH, width 128) with count output. It has push/pop/full/empty and the same clock and reset.
- Top instantiates the FSM, holding regs, timer and the FIFO. It does not instantiate `aes_cipher_top`; the integrating top connects the `core_*` ports.

## Test plan
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, `out_ready`=1 → exactly one `core_ld` pulse one cycle after accept; `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a; `blk_cnt`=1; `err`=0.
- Back-pressure: `out_ready`=0, offer 3 blocks → 2 complete; `in_ready`=0 with count=2; third block held upstream. Then `out_ready`=1 → all 3 emerge in order, ciphertexts match the model.
- Watchdog: core stub never asserts done → `err`=1 exactly TIMEOUT cycles into BUSY; no buffer write; `in_ready`=1 next cycle; `err` stays 1 after further good blocks.
- Done-on-timeout-cycle: stub asserts `core_done` exactly at timer==TIMEOUT → block written, `err`=0.
- Simultaneous push/pop: buffer count=1 and `out_ready`=1 on the `core_done` cycle → count stays 1; old head emitted, then new block.
- Reset mid-BUSY and with buffer full → after `rst` low one cycle: all outputs at reset values, `out_valid`=0, `blk_cnt`=0; next vector encrypts correctly.
